// File: rtl/mprj_io_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mprj_io_serial_loader
//  Description : Serial configuration loader for the user-project GPIO chain.
//                On xfer_start it walks the pads from IO_PADS-1 down to 0.
//                For each pad it reads the control word from the mprj_ctrl
//                register file and shifts it MSB first into the daisy-chained
//                gpio_control_block shift registers. It then strobes
//                serial_load so that every pad applies its new setting at
//                the same time.
//
//  Ports       : wb_clk_i         in   system clock (only clock)
//                wb_rst_i         in   synchronous reset, active high
//                xfer_start       in   single-cycle start request
//                cfg_rd_addr      out  pad index presented to the register file
//                cfg_rd_data      in   control word, valid 1 cycle after addr
//                xfer_busy        out  transfer in progress
//                xfer_done        out  1-cycle pulse at transfer completion
//                serial_clock     out  chain shift clock
//                serial_data_out  out  chain data, changes only with clock low
//                serial_load      out  latch strobe for the whole chain
//
//  Revision    : 1.0  initial release
// ============================================================================
module mprj_io_serial_loader #(
    parameter int IO_PADS       = 38,
    parameter int PAD_CTRL_BITS = 13,
    parameter int CLK_DIV       = 2,
    localparam int ADDR_W       = (IO_PADS > 1) ? $clog2(IO_PADS) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              xfer_start,
    output logic [ADDR_W-1:0] cfg_rd_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_rd_data,
    output logic              xfer_busy,
    output logic              xfer_done,
    output logic              serial_clock,
    output logic              serial_data_out,
    output logic              serial_load
);

    // One counter serves both the per-phase divider in SHIFT and the
    // 2*CLK_DIV load strobe, so it is sized for the larger of the two.
    localparam int BIT_W = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 0) ? $clog2(2 * CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  c_phase_last = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  c_load_last  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  c_bit_last   = BIT_W'(PAD_CTRL_BITS - 1);
    localparam logic [ADDR_W-1:0] c_pad_first  = ADDR_W'(IO_PADS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_D = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_LOAD    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [ADDR_W-1:0]        r_pad_idx;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [DIV_W-1:0]         r_div_cnt;
    logic                     r_phase;      // 0: clock low half, 1: clock high half
    logic [PAD_CTRL_BITS-1:0] r_shreg;

    logic                     w_phase_end;
    logic                     w_bit_end;
    logic                     w_pad_end;
    logic                     w_load_end;

    assign w_phase_end = (r_div_cnt == c_phase_last);
    assign w_bit_end   = w_phase_end && r_phase;
    assign w_pad_end   = w_bit_end && (r_bit_cnt == c_bit_last);
    assign w_load_end  = (r_div_cnt == c_load_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. Outputs depend only on registered
    // state, so there is no input-to-output combinational path.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        cfg_rd_addr     = r_pad_idx;
        xfer_busy       = 1'b0;
        xfer_done       = 1'b0;
        serial_clock    = 1'b0;
        serial_data_out = 1'b0;
        serial_load     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                cfg_rd_addr = '0;
                if (xfer_start) begin
                    w_state_next = ST_FETCH_A;
                end
            end
            ST_FETCH_A: begin
                xfer_busy    = 1'b1;
                w_state_next = ST_FETCH_D;
            end
            ST_FETCH_D: begin
                xfer_busy    = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                xfer_busy       = 1'b1;
                serial_clock    = r_phase;
                serial_data_out = r_shreg[PAD_CTRL_BITS-1];
                if (w_pad_end) begin
                    w_state_next = (r_pad_idx == '0) ? ST_LOAD : ST_FETCH_A;
                end
            end
            ST_LOAD: begin
                xfer_busy   = 1'b1;
                serial_load = 1'b1;
                if (w_load_end) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Start requests here are dropped: the FSM always returns
                // to IDLE first.
                xfer_done    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pad index, bit counter, clock divider and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pad_idx <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_shreg   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_div_cnt <= '0;
                    r_phase   <= 1'b0;
                    if (xfer_start) begin
                        r_pad_idx <= c_pad_first;
                    end
                end
                ST_FETCH_D: begin
                    // Read data returned for the address driven in FETCH_A.
                    r_shreg   <= cfg_rd_data;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    r_phase   <= 1'b0;
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        if (r_phase) begin
                            // End of the high half: advance to the next bit
                            // so data only moves while the clock goes low.
                            r_phase   <= 1'b0;
                            r_shreg   <= {r_shreg[PAD_CTRL_BITS-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_pad_end && (r_pad_idx != '0)) begin
                                r_pad_idx <= r_pad_idx - 1'b1;
                            end
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_load_end) begin
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mprj_io_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mprj_io_serial_loader
//  Description : Self-checking bench for mprj_io_serial_loader. Three
//                instances (CLK_DIV = 2, 1, 3) share one register-file model.
//                A monitor keeps a shadow of the 38x13 daisy chain plus
//                timing statistics; expectations come from the pad words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mprj_io_serial_loader;

    localparam int IO_PADS = 38;
    localparam int BITS    = 13;
    localparam int CHAIN   = IO_PADS * BITS;
    localparam int N       = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   start;
    logic [N-1:0]   busy, done, sc, sd, load;
    logic [5:0]     addr [N];
    logic [12:0]    rdd  [N];
    logic [12:0]    pad_word [IO_PADS];

    function automatic int cd_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int CD = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
            mprj_io_serial_loader #(
                .IO_PADS       (IO_PADS),
                .PAD_CTRL_BITS (BITS),
                .CLK_DIV       (CD)
            ) u_dut (
                .wb_clk_i        (clk),
                .wb_rst_i        (rst),
                .xfer_start      (start[g]),
                .cfg_rd_addr     (addr[g]),
                .cfg_rd_data     (rdd[g]),
                .xfer_busy       (busy[g]),
                .xfer_done       (done[g]),
                .serial_clock    (sc[g]),
                .serial_data_out (sd[g]),
                .serial_load     (load[g])
            );
        end
    endgenerate

    // Register file: data appears one cycle after the address.
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            rdd[g] <= (int'(addr[g]) < IO_PADS) ? pad_word[addr[g]] : 13'h0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: shadow chain and statistics, sampled on the falling edge
    // ------------------------------------------------------------------
    int             xfer_cnt [N], done_cnt [N], load_cnt [N];
    int             busy_run [N], busy_len [N], load_run [N], load_w [N];
    int             hi_run [N], lo_run [N], rise_idx [N];
    int             pviol [N], dviol [N], addr_n [N];
    logic [5:0]     addr_seq [N][IO_PADS];
    logic [CHAIN-1:0] chain [N], chain_snap [N];
    logic [N-1:0]   p_busy, p_done, p_sc, p_sd, p_load;
    logic [5:0]     p_addr [N];

    initial begin
        p_busy = '0; p_done = '0; p_sc = '0; p_sd = '0; p_load = '0;
        for (int g = 0; g < N; g++) begin
            xfer_cnt[g] = 0; done_cnt[g] = 0; load_cnt[g] = 0;
            busy_run[g] = 0; busy_len[g] = 0; load_run[g] = 0; load_w[g] = 0;
            hi_run[g] = 0; lo_run[g] = 0; rise_idx[g] = 0;
            pviol[g] = 0; dviol[g] = 0; addr_n[g] = 0;
            chain[g] = '0; chain_snap[g] = '0; p_addr[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                int cd;
                cd = cd_of(g);
                if (busy[g] === 1'b1 && !p_busy[g]) begin
                    xfer_cnt[g]++;
                    rise_idx[g] = 0;
                    busy_run[g] = 0;
                    addr_n[g]   = 0;
                    chain[g]    = '0;
                end
                if (busy[g] === 1'b1) begin
                    busy_run[g]++;
                    if (!p_busy[g] || addr[g] != p_addr[g]) begin
                        if (addr_n[g] < IO_PADS) addr_seq[g][addr_n[g]] = addr[g];
                        addr_n[g]++;
                    end
                end
                if (busy[g] !== 1'b1 && p_busy[g]) busy_len[g] = busy_run[g];

                if (sc[g] === 1'b1) begin
                    if (!p_sc[g]) begin
                        if (rise_idx[g] > 0) begin
                            if (lo_run[g] != (((rise_idx[g] % BITS) == 0) ? cd + 2 : cd))
                                pviol[g]++;
                        end
                        rise_idx[g]++;
                        chain[g] = {chain[g][CHAIN-2:0], sd[g]};
                        hi_run[g] = 1;
                    end else begin
                        hi_run[g]++;
                    end
                    if (sd[g] !== p_sd[g]) dviol[g]++;
                end else begin
                    if (p_sc[g]) begin
                        if (hi_run[g] != cd) pviol[g]++;
                        lo_run[g] = 1;
                    end else begin
                        lo_run[g]++;
                    end
                end

                if (load[g] === 1'b1) begin
                    if (!p_load[g]) begin
                        load_cnt[g]++;
                        chain_snap[g] = chain[g];
                        load_run[g] = 1;
                    end else begin
                        load_run[g]++;
                    end
                    if (sc[g] !== 1'b0 || sd[g] !== 1'b0) dviol[g]++;
                end else if (p_load[g]) begin
                    load_w[g] = load_run[g];
                end

                if (done[g] === 1'b1) begin
                    if (!p_done[g]) done_cnt[g]++;
                    else dviol[g]++;
                    if (busy[g] !== 1'b0) dviol[g]++;
                end

                p_busy[g] = (busy[g] === 1'b1);
                p_done[g] = (done[g] === 1'b1);
                p_sc[g]   = (sc[g] === 1'b1);
                p_sd[g]   = (sd[g] === 1'b1);
                p_load[g] = (load[g] === 1'b1);
                p_addr[g] = addr[g];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-chain image: pad IO_PADS-1 first, each word MSB first.
    function automatic logic [CHAIN-1:0] exp_stream();
        logic [CHAIN-1:0] s;
        s = '0;
        for (int k = IO_PADS - 1; k >= 0; k--) begin
            s = (s << BITS) | CHAIN'(pad_word[k]);
        end
        return s;
    endfunction

    task automatic wait_done(input int g, input int d0, input string nm);
        int c;
        c = 0;
        while (done_cnt[g] == d0 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt[g] == d0) chk({nm, "_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic check_xfer(input int g, input int pv0, input int dv0,
                              input int dn0, input string nm);
        int cd;
        cd = cd_of(g);
        chk({nm, "_busy_len"}, busy_len[g], IO_PADS * (2 + 2 * cd * BITS) + 2 * cd);
        chk({nm, "_rises"}, rise_idx[g], CHAIN);
        chk({nm, "_load_w"}, load_w[g], 2 * cd);
        chk({nm, "_done_pulses"}, done_cnt[g] - dn0, 1);
        chk({nm, "_phase_err"}, pviol[g] - pv0, 0);
        chk({nm, "_data_err"}, dviol[g] - dv0, 0);
        chk({nm, "_stream"}, {63'd0, chain_snap[g] == exp_stream()}, 64'd1);
        for (int k = 0; k < IO_PADS; k++) begin
            chk($sformatf("%s_pad%0d", nm, k), chain_snap[g][k*BITS +: BITS], pad_word[k]);
        end
        chk({nm, "_addr_n"}, addr_n[g], IO_PADS);
        for (int i = 0; i < IO_PADS; i++) begin
            chk($sformatf("%s_addr%0d", nm, i), addr_seq[g][i], IO_PADS - 1 - i);
        end
    endtask

    task automatic pulse(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic check_outputs_zero(input int g, input string nm);
        chk({nm, "_busy"}, busy[g], 0);
        chk({nm, "_done"}, done[g], 0);
        chk({nm, "_sclk"}, sc[g], 0);
        chk({nm, "_sdata"}, sd[g], 0);
        chk({nm, "_load"}, load[g], 0);
        chk({nm, "_addr"}, addr[g], 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int pv0, dv0, dn0, pv1, dv1, dn1, xf0, ld0, n, c;
        rst   = 1'b1;
        start = '0;
        for (int k = 0; k < IO_PADS; k++) pad_word[k] = 13'h1000 | 13'(k);

        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) check_outputs_zero(g, $sformatf("reset%0d", g));
        rst = 1'b0;

        // Single full transfer, pad k = 0x1000|k
        pv0 = pviol[0]; dv0 = dviol[0]; dn0 = done_cnt[0];
        pulse(0);
        wait_done(0, dn0, "full");
        check_xfer(0, pv0, dv0, dn0, "full");

        // CLK_DIV = 1 and 3 with random words
        for (int k = 0; k < IO_PADS; k++) pad_word[k] = 13'($urandom);
        pv0 = pviol[1]; dv0 = dviol[1]; dn0 = done_cnt[1];
        pv1 = pviol[2]; dv1 = dviol[2]; dn1 = done_cnt[2];
        @(negedge clk);
        start[1] = 1'b1; start[2] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0; start[2] = 1'b0;
        wait_done(1, dn0, "div1");
        wait_done(2, dn1, "div3");
        check_xfer(1, pv0, dv0, dn0, "div1");
        check_xfer(2, pv1, dv1, dn1, "div3");

        // Extra start requests during busy and in the DONE cycle
        for (int k = 0; k < IO_PADS; k++) pad_word[k] = 13'($urandom);
        pv0 = pviol[0]; dv0 = dviol[0]; dn0 = done_cnt[0]; xf0 = xfer_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        n = 0;
        for (c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (busy[0] === 1'b1) n++;
            start[0] = ((busy[0] === 1'b1) && (n == 1 || n == 500 || n == 2055))
                       || (done[0] === 1'b1);
            if (done[0] === 1'b1) break;
        end
        if (c >= 4000) chk("multi_timeout", 64'd0, 64'd1);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("multi_xfers", xfer_cnt[0] - xf0, 1);
        chk("multi_busy_after", busy[0], 0);
        check_xfer(0, pv0, dv0, dn0, "multi");

        // Reset in the middle of a transfer
        for (int k = 0; k < IO_PADS; k++) pad_word[k] = 13'($urandom);
        dn0 = done_cnt[0]; ld0 = load_cnt[0];
        pulse(0);
        n = 1;
        c = 0;
        while (n < 1000 && c < 4000) begin
            @(negedge clk);
            if (busy[0] === 1'b1) n++;
            c++;
        end
        chk("rst_reached_1000", n, 1000);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero(0, "midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_done_cnt", done_cnt[0] - dn0, 0);
        chk("midrst_load_cnt", load_cnt[0] - ld0, 0);
        chk("midrst_busy_after", busy[0], 0);
        pv0 = pviol[0]; dv0 = dviol[0]; dn0 = done_cnt[0];
        pulse(0);
        wait_done(0, dn0, "after_rst");
        check_xfer(0, pv0, dv0, dn0, "after_rst");

        // Alternating pattern
        for (int k = 0; k < IO_PADS; k++) pad_word[k] = (k % 2 == 0) ? 13'h1555 : 13'h0AAA;
        pv0 = pviol[0]; dv0 = dviol[0]; dn0 = done_cnt[0];
        pulse(0);
        wait_done(0, dn0, "pattern");
        check_xfer(0, pv0, dv0, dn0, "pattern");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
